// File: rtl/vfd_ramp_ctrl.sv
// rtl/vfd_ramp_ctrl.sv - soft-start V/Hz ramp sequencer driving NCO phase increment, amplitude and bridge enable
module vfd_ramp_ctrl #(
  parameter int FREQ_BITS      = 8,
  parameter int PHASE_ACC_BITS = 24,
  parameter int MOD_BITS       = 10,
  parameter int INC_PER_UNIT   = 84,
  parameter int STEP_DIV       = 200,
  parameter int ACC_STEP       = 1,
  parameter int VF_GAIN        = 4,
  parameter int V_BOOST        = 16,
  parameter int AMP_MAX        = 2**MOD_BITS-1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [FREQ_BITS-1:0]      cmd_freq,
  input  logic                      stop_req,
  input  logic                      fault,
  input  logic                      fault_clr,
  output logic [PHASE_ACC_BITS-1:0] phase_inc,
  output logic [MOD_BITS-1:0]       amp,
  output logic                      drv_en,
  output logic                      at_speed,
  output logic [2:0]                state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_RUN   = 3'd2,
    S_FAULT = 3'd3
  } state_t;

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [FREQ_BITS-1:0] STEP = FREQ_BITS'(ACC_STEP);
  // Wide enough that boost + freq*gain cannot wrap before the clamp compare.
  localparam int AW = FREQ_BITS + 24;

  state_t                    state_q, state_d;
  logic [FREQ_BITS-1:0]      target_q, target_d;
  logic [FREQ_BITS-1:0]      cur_q, cur_d;
  logic [PW-1:0]             presc_q, presc_d;
  logic [PHASE_ACC_BITS-1:0] phase_inc_q, phase_inc_d;
  logic [MOD_BITS-1:0]       amp_q, amp_d;
  logic                      drv_en_q, at_speed_q;
  logic [FREQ_BITS-1:0]      cur_step;
  logic [AW-1:0]             amp_raw;
  logic                      cmd_accept;

  // Commands are refused while stopping or faulted; stop outranks a same-cycle command.
  assign cmd_ready  = (state_q != S_FAULT) & ~stop_req & ~fault;
  assign cmd_accept = cmd_valid & cmd_ready;

  assign phase_inc = phase_inc_q;
  assign amp       = amp_q;
  assign drv_en    = drv_en_q;
  assign at_speed  = at_speed_q;
  assign state_o   = state_q;

  // One ramp step toward the current target, landing exactly on it when closer than ACC_STEP.
  always_comb begin
    cur_step = cur_q;
    if (target_q > cur_q) begin
      cur_step = ((target_q - cur_q) > STEP) ? cur_q + STEP : target_q;
    end else if (target_q < cur_q) begin
      cur_step = ((cur_q - target_q) > STEP) ? cur_q - STEP : target_q;
    end
  end

  // Sequencer next-state: fault wins, then stop, then commands.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cur_d    = cur_q;
    presc_d  = presc_q;
    if (fault) begin
      state_d  = S_FAULT;
      target_d = '0;
      cur_d    = '0;
      presc_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cur_d = '0;
          if (stop_req) begin
            target_d = '0;
          end else if (cmd_accept) begin
            target_d = cmd_freq;
            if (cmd_freq != '0) begin
              state_d = S_RAMP;
              presc_d = '0;
            end
          end
        end
        S_RAMP: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            cur_d   = cur_step;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (stop_req) begin
            target_d = '0;
          end else if (cmd_accept) begin
            target_d = cmd_freq;
          end
          if (cur_d == target_d) begin
            state_d = (target_d != '0) ? S_RUN : S_IDLE;
          end
        end
        S_RUN: begin
          if (stop_req) begin
            target_d = '0;
            state_d  = S_RAMP;
            presc_d  = '0;
          end else if (cmd_accept && (cmd_freq != target_q)) begin
            target_d = cmd_freq;
            state_d  = S_RAMP;
            presc_d  = '0;
          end
        end
        S_FAULT: begin
          target_d = '0;
          cur_d    = '0;
          presc_d  = '0;
          if (fault_clr) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d  = S_IDLE;
          target_d = '0;
          cur_d    = '0;
          presc_d  = '0;
        end
      endcase
    end
  end

  // V/Hz mapping of the present frequency; registered below so outputs trail cur_freq by one clock.
  always_comb begin
    phase_inc_d = PHASE_ACC_BITS'(cur_q) * PHASE_ACC_BITS'(INC_PER_UNIT);
    amp_raw     = AW'(V_BOOST) + AW'(cur_q) * AW'(VF_GAIN);
    amp_d       = '0;
    if (cur_q != '0) begin
      amp_d = (amp_raw > AW'(AMP_MAX)) ? MOD_BITS'(AMP_MAX) : amp_raw[MOD_BITS-1:0];
    end
  end

  // Sequencer state, target, current frequency and step prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      cur_q    <= '0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      presc_q  <= presc_d;
    end
  end

  // Datapath outputs; a fault kills drive on the very edge it is sampled.
  always_ff @(posedge clk) begin
    if (rst || fault) begin
      phase_inc_q <= '0;
      amp_q       <= '0;
      drv_en_q    <= 1'b0;
      at_speed_q  <= 1'b0;
    end else begin
      phase_inc_q <= phase_inc_d;
      amp_q       <= amp_d;
      drv_en_q    <= (cur_q != '0) && (state_q != S_FAULT);
      at_speed_q  <= (state_q == S_RUN);
    end
  end

endmodule

// File: tb/tb_vfd_ramp_ctrl.sv
// tb/tb_vfd_ramp_ctrl.sv - self-checking bench for vfd_ramp_ctrl with directed and random stimulus
module tb_vfd_ramp_ctrl;

  localparam int FB = 8;
  localparam int PB = 24;
  localparam int MB = 10;
  localparam int SD = 4;
  localparam int AS = 1;
  localparam int IPU = 100;
  localparam int GAIN = 4;
  localparam int BOOST = 16;
  localparam int AMAX = 1023;

  localparam int ST_IDLE = 0;
  localparam int ST_RAMP = 1;
  localparam int ST_RUN = 2;
  localparam int ST_FAULT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [FB-1:0] cmd_freq = '0;
  logic stop_req = 1'b0;
  logic fault = 1'b0;
  logic fault_clr = 1'b0;
  logic [PB-1:0] phase_inc;
  logic [MB-1:0] amp;
  logic drv_en;
  logic at_speed;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  int m_state, m_target, m_cur, m_cnt;
  int e_phase, e_amp, e_drv, e_at, e_ready;

  vfd_ramp_ctrl #(
    .FREQ_BITS(FB), .PHASE_ACC_BITS(PB), .MOD_BITS(MB), .INC_PER_UNIT(IPU),
    .STEP_DIV(SD), .ACC_STEP(AS), .VF_GAIN(GAIN), .V_BOOST(BOOST), .AMP_MAX(AMAX)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_freq(cmd_freq), .stop_req(stop_req), .fault(fault), .fault_clr(fault_clr),
    .phase_inc(phase_inc), .amp(amp), .drv_en(drv_en), .at_speed(at_speed),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: what the controller should do on the coming edge given the present inputs.
  task automatic model_step();
    bit accept;
    if (rst) begin
      m_state = ST_IDLE; m_target = 0; m_cur = 0; m_cnt = 0;
      e_phase = 0; e_amp = 0; e_drv = 0; e_at = 0;
      return;
    end
    if (fault) begin
      e_phase = 0; e_amp = 0; e_drv = 0; e_at = 0;
    end else begin
      e_phase = (m_cur * IPU) % (1 << PB);
      e_amp = (m_cur == 0) ? 0 : min2(BOOST + m_cur * GAIN, AMAX);
      e_drv = (m_cur != 0 && m_state != ST_FAULT) ? 1 : 0;
      e_at = (m_state == ST_RUN) ? 1 : 0;
    end
    accept = cmd_valid && (m_state != ST_FAULT) && !stop_req && !fault;
    if (fault) begin
      m_state = ST_FAULT; m_target = 0; m_cur = 0;
      return;
    end
    case (m_state)
      ST_IDLE: begin
        if (stop_req) m_target = 0;
        else if (accept) begin
          m_target = int'(cmd_freq);
          if (m_target > 0) begin m_state = ST_RAMP; m_cnt = 0; end
        end
      end
      ST_RAMP: begin
        if (m_cnt == SD - 1) begin
          if (m_target > m_cur) m_cur += min2(AS, m_target - m_cur);
          else if (m_target < m_cur) m_cur -= min2(AS, m_cur - m_target);
        end
        m_cnt = (m_cnt + 1) % SD;
        if (stop_req) m_target = 0;
        else if (accept) m_target = int'(cmd_freq);
        if (m_cur == m_target) m_state = (m_target != 0) ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (stop_req) begin m_target = 0; m_state = ST_RAMP; m_cnt = 0; end
        else if (accept && int'(cmd_freq) != m_target) begin
          m_target = int'(cmd_freq); m_state = ST_RAMP; m_cnt = 0;
        end
      end
      default: begin
        m_target = 0; m_cur = 0;
        if (fault_clr) m_state = ST_IDLE;
      end
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    e_ready = (m_state != ST_FAULT && !stop_req && !fault) ? 1 : 0;
    chk("phase_inc", phase_inc, e_phase);
    chk("amp", amp, e_amp);
    chk("drv_en", drv_en, e_drv);
    chk("at_speed", at_speed, e_at);
    chk("state_o", state_o, m_state);
    chk("cmd_ready", cmd_ready, e_ready);
  endtask

  task automatic send_cmd(input int f);
    cmd_valid = 1'b1;
    cmd_freq = f[FB-1:0];
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_state(input string tag, input int code, input int bound, output int n);
    bit found = 0;
    n = 0;
    while (!found && n < bound) begin
      cycle();
      n++;
      if (state_o == code[2:0]) found = 1;
    end
    chk(tag, found, 1);
  endtask

  initial begin
    int n;
    int max_phase;
    bit seen;

    // 1: reset held three clocks
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    chk("rst_phase", phase_inc, 0);
    chk("rst_amp", amp, 0);
    chk("rst_drv", drv_en, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_state", state_o, ST_IDLE);
    cycle();

    // 2: ramp 0 -> 10 at one unit per four clocks
    send_cmd(10);
    wait_state("t2_reach_run", ST_RUN, 100, n);
    chk("t2_run_latency", n, 40);
    cycle();
    chk("t2_phase", phase_inc, 1000);
    chk("t2_amp", amp, 56);
    chk("t2_at_speed", at_speed, 1);

    // back to idle, then 3: retarget downward mid-ramp
    stop_req = 1'b1;
    cycle();
    stop_req = 1'b0;
    wait_state("t3_idle", ST_IDLE, 100, n);
    send_cmd(10);
    n = 0;
    while (m_cur != 7 && n < 100) begin cycle(); n++; end
    chk("t3_reach7", (m_cur == 7) ? 1 : 0, 1);
    send_cmd(5);
    max_phase = 0;
    n = 0;
    while (state_o != ST_RUN && n < 100) begin
      cycle();
      n++;
      if (int'(phase_inc) > max_phase) max_phase = int'(phase_inc);
    end
    chk("t3_no_overshoot", (max_phase <= 700) ? 1 : 0, 1);
    cycle();
    cycle();
    chk("t3_phase", phase_inc, 500);
    chk("t3_amp", amp, 36);
    chk("t3_state", state_o, ST_RUN);

    // 4: stop beats a same-cycle command
    stop_req = 1'b1;
    cmd_valid = 1'b1;
    cmd_freq = 8'd20;
    #1;
    chk("t4_ready_low", cmd_ready, 0);
    cycle();
    stop_req = 1'b0;
    cmd_valid = 1'b0;
    wait_state("t4_idle", ST_IDLE, 100, n);
    cycle();
    chk("t4_drv", drv_en, 0);
    chk("t4_phase", phase_inc, 0);

    // 5: fault shutdown and clear handshake
    send_cmd(10);
    wait_state("t5_run", ST_RUN, 100, n);
    cycle();
    fault = 1'b1;
    cycle();
    chk("t5_drv", drv_en, 0);
    chk("t5_phase", phase_inc, 0);
    chk("t5_amp", amp, 0);
    chk("t5_ready", cmd_ready, 0);
    chk("t5_state", state_o, ST_FAULT);
    fault_clr = 1'b1;
    cycle();
    chk("t5_clr_ignored", state_o, ST_FAULT);
    fault = 1'b0;
    fault_clr = 1'b0;
    cycle();
    chk("t5_still_fault", state_o, ST_FAULT);
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    chk("t5_cleared", state_o, ST_IDLE);
    chk("t5_ready_back", cmd_ready, 1);

    // 6: full-scale command, amplitude clamp
    send_cmd(255);
    seen = 0;
    n = 0;
    while (state_o != ST_RUN && n < 1100) begin
      cycle();
      n++;
      if (!seen && amp == 10'd1023) begin
        seen = 1;
        chk("t6_clamp_onset", phase_inc, 25200);
      end
    end
    chk("t6_run", state_o, ST_RUN);
    cycle();
    chk("t6_phase", phase_inc, 25500);
    chk("t6_amp", amp, 1023);

    // random traffic against the reference
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cmd_valid = $urandom_range(0, 1);
      cmd_freq = 8'($urandom_range(0, 24));
      stop_req = ($urandom_range(0, 24) == 0);
      fault = ($urandom_range(0, 59) == 0);
      fault_clr = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
